sd_spi_arbiter: RTL

- Shares the single SD-card SPI port (sd_cs0_n / sd_sclk / sd_mosi / sd_miso) between two requesters. Port A is the MSX core MegaSD path. Port B is the boot/loader path.
- Contains a fair grant arbiter and a byte-wide SPI mode-0 shift engine.
- Sits between the requesters and the board SD pins inside the top level, clocked by sysclk.

---
 rtl/sd_spi_arbiter_if.sv | 46 ++++
 rtl/sd_spi_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sd_spi_arbiter_if.sv
// Purpose: requester-side and card-side signals of the shared SD SPI port.
// Latency: none, this is only a signal bundle.
// Backpressure: a requester may only start a byte while it holds the grant and the engine is idle.
interface sd_spi_arbiter_if;
    // Port A: MSX core MegaSD path
    logic       a_req;
    logic       a_gnt;
    logic       a_cs_n;
    logic       a_start;
    logic [7:0] a_tx;
    logic [7:0] a_rx;
    logic       a_busy;
    logic       a_done;
    // Port B: boot/loader path
    logic       b_req;
    logic       b_gnt;
    logic       b_cs_n;
    logic       b_start;
    logic [7:0] b_tx;
    logic [7:0] b_rx;
    logic       b_busy;
    logic       b_done;
    // Board SD pins
    logic       sd_cs_n;
    logic       sd_sclk;
    logic       sd_mosi;
    logic       sd_miso;

    modport slave (
        input  a_req, a_cs_n, a_start, a_tx,
        output a_gnt, a_rx, a_busy, a_done,
        input  b_req, b_cs_n, b_start, b_tx,
        output b_gnt, b_rx, b_busy, b_done,
        output sd_cs_n, sd_sclk, sd_mosi,
        input  sd_miso
    );

    modport master (
        output a_req, a_cs_n, a_start, a_tx,
        input  a_gnt, a_rx, a_busy, a_done,
        output b_req, b_cs_n, b_start, b_tx,
        input  b_gnt, b_rx, b_busy, b_done,
        input  sd_cs_n, sd_sclk, sd_mosi,
        output sd_miso
    );
endinterface

// File: rtl/sd_spi_arbiter.sv
// Purpose: round-robin arbiter sharing one SD SPI port between two requesters, with a mode-0 byte engine.
// Latency: grant 1 cycle after request; byte done 1+16*CLK_DIV cycles after an accepted start.
// Backpressure: start is ignored unless the port holds the grant and the engine is idle.
module sd_spi_arbiter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic          clock,
    input  logic          reset,
    sd_spi_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state, state_next;
    logic       last_owner_b;   // 1: B owned the bus most recently
    logic       a_gnt_q, b_gnt_q;
    logic       cs_n_q;

    logic       busy_q;
    logic       port_b_q;       // which port the byte in flight belongs to
    logic [7:0] sh_q;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic       sclk_q;
    logic       mosi_q;
    logic [7:0] a_rx_q, b_rx_q;
    logic       a_done_q, b_done_q;

    logic       a_acc, b_acc, start_acc;
    logic [7:0] start_byte;
    logic       div_wrap;

    assign a_acc      = bus.a_start & a_gnt_q & ~busy_q;
    assign b_acc      = bus.b_start & b_gnt_q & ~busy_q;
    assign start_acc  = a_acc | b_acc;
    assign start_byte = a_acc ? bus.a_tx : bus.b_tx;
    assign div_wrap   = busy_q && (div_cnt == DIV_LAST);

    // Arbiter next state: alternate on contention, always pass through IDLE between owners
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.a_req && bus.b_req)
                    state_next = last_owner_b ? OWN_A : OWN_B;
                else if (bus.a_req)
                    state_next = OWN_A;
                else if (bus.b_req)
                    state_next = OWN_B;
            end
            OWN_A: begin
                if (!bus.a_req && !busy_q && !a_acc)
                    state_next = IDLE;
            end
            OWN_B: begin
                if (!bus.b_req && !busy_q && !b_acc)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Arbiter state, registered grants and round-robin history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            a_gnt_q      <= 1'b0;
            b_gnt_q      <= 1'b0;
            last_owner_b <= 1'b1;
        end else begin
            state   <= state_next;
            a_gnt_q <= (state_next == OWN_A);
            b_gnt_q <= (state_next == OWN_B);
            if (state == OWN_A && state_next == IDLE)
                last_owner_b <= 1'b0;
            else if (state == OWN_B && state_next == IDLE)
                last_owner_b <= 1'b1;
        end
    end

    // Chip select follows the owner's request only between bytes; deasserted whenever unowned
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs_n_q <= 1'b1;
        end else if (state_next == IDLE) begin
            cs_n_q <= 1'b1;
        end else if (state == OWN_A && !busy_q) begin
            cs_n_q <= bus.a_cs_n;
        end else if (state == OWN_B && !busy_q) begin
            cs_n_q <= bus.b_cs_n;
        end
    end

    // Byte engine: sample MISO on SCLK rise, advance MOSI on SCLK fall, finish after 8 pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q   <= 1'b0;
            port_b_q <= 1'b0;
            sh_q     <= 8'h00;
            div_cnt  <= 8'h00;
            bit_cnt  <= 3'd0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            a_rx_q   <= 8'h00;
            b_rx_q   <= 8'h00;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
        end else begin
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            if (busy_q) begin
                if (div_wrap) begin
                    div_cnt <= 8'h00;
                    sclk_q  <= ~sclk_q;
                    if (!sclk_q) begin
                        sh_q <= {sh_q[6:0], bus.sd_miso};
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            busy_q <= 1'b0;
                            mosi_q <= 1'b1;
                            if (port_b_q) begin
                                b_rx_q   <= sh_q;
                                b_done_q <= 1'b1;
                            end else begin
                                a_rx_q   <= sh_q;
                                a_done_q <= 1'b1;
                            end
                        end else begin
                            mosi_q <= sh_q[7];
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end else if (start_acc) begin
                busy_q   <= 1'b1;
                port_b_q <= b_acc;
                sh_q     <= start_byte;
                mosi_q   <= start_byte[7];
                div_cnt  <= 8'h00;
                bit_cnt  <= 3'd0;
                sclk_q   <= 1'b0;
            end
        end
    end

    assign bus.a_gnt   = a_gnt_q;
    assign bus.b_gnt   = b_gnt_q;
    assign bus.a_busy  = busy_q & ~port_b_q;
    assign bus.b_busy  = busy_q &  port_b_q;
    assign bus.a_done  = a_done_q;
    assign bus.b_done  = b_done_q;
    assign bus.a_rx    = a_rx_q;
    assign bus.b_rx    = b_rx_q;
    assign bus.sd_cs_n = cs_n_q;
    assign bus.sd_sclk = sclk_q;
    assign bus.sd_mosi = mosi_q;

endmodule
